// File: rtl/change_pkg.sv
// change_pkg: shared types and constants for the change dispenser.
//   state_t    - dispenser FSM states
//   AMT_W      - width of Rs amounts
//   COIN_HI_RS - value of the large coin (Rs10)
//   COIN_LO_RS - value of the small coin (Rs5)
//   pick_hi()  - coin selection: large coin if it fits and is available
package change_pkg;

    localparam int AMT_W = 5;
    localparam logic [AMT_W-1:0] COIN_HI_RS = AMT_W'(10);
    localparam logic [AMT_W-1:0] COIN_LO_RS = AMT_W'(5);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        DONE
    } state_t;

    // True when the next coin should be Rs10. no_hi forces Rs5 coins
    // (e.g. Rs10 tube empty), so Rs10 is paid as two Rs5 coins.
    function automatic logic pick_hi(input logic [AMT_W-1:0] amt,
                                     input logic no_hi);
        return (amt >= COIN_HI_RS) && !no_hi;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// dispense_timer: loadable up-counter used to time out a coin request.
//   clk       - system clock, rising edge
//   reset     - synchronous, active-low reset
//   clear     - force count to zero (highest priority after reset)
//   load      - load count from load_val
//   load_val  - value to load
//   en        - count up by one
//   expired   - count has reached TIMEOUT_CYCLES-1
// TMR_W must satisfy 2**TMR_W > TIMEOUT_CYCLES.
module dispense_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= count + 1'b1;
    end

    assign expired = (count == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a Rs change amount into Rs10/Rs5 coin requests
// and drives the coin hopper one coin at a time with a req/ack handshake.
//   clk          - system clock, rising edge
//   reset        - synchronous, active-low reset
//   change_valid - change_amt valid; accepted while ready=1
//   change_amt   - change owed in Rs (0..31)
//   ready        - idle, able to accept an amount
//   hopper_ack   - hopper ejected the requested coin (only looked at in REQ)
//   empty10      - Rs10 tube empty (only with CHANGE_FALLBACK_EN defined)
//   coin10_req   - request one Rs10 coin, held until acked
//   coin5_req    - request one Rs5 coin, held until acked
//   done         - one-cycle pulse, full amount dispensed
//   err          - one-cycle pulse, amount not a multiple of 5
//   fault        - one-cycle pulse, hopper did not ack in time
//   remain_amt   - Rs still owed (unpaid balance on fault)
// Build option: define CHANGE_FALLBACK_EN to add empty10 and pay Rs10
// as two Rs5 coins while the Rs10 tube is empty.
module change_dispenser
    import change_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TMR_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             ready,
    input  logic             hopper_ack,
`ifdef CHANGE_FALLBACK_EN
    input  logic             empty10,
`endif
    output logic             coin10_req,
    output logic             coin5_req,
    output logic             done,
    output logic             err,
    output logic             fault,
    output logic [AMT_W-1:0] remain_amt
);

    state_t           state;
    logic             no_hi;
    logic             tmr_clear;
    logic             tmr_en;
    logic             tmr_expired;
    logic [AMT_W-1:0] coin_val;

`ifdef CHANGE_FALLBACK_EN
    assign no_hi = empty10;
`else
    assign no_hi = 1'b0;
`endif

    // Value of the coin currently being requested.
    assign coin_val = coin10_req ? COIN_HI_RS : COIN_LO_RS;

    // Timer runs only while waiting for an ack; any ack or leaving REQ
    // restarts it so every coin gets the full timeout window.
    assign tmr_clear = (state != REQ) || hopper_ack;
    assign tmr_en    = (state == REQ) && !hopper_ack;

    dispense_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .load     (1'b0),
        .load_val ('0),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            ready      <= 1'b1;
            coin10_req <= 1'b0;
            coin5_req  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            fault      <= 1'b0;
            remain_amt <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (change_valid && ready) begin
                        remain_amt <= change_amt;
                        if (change_amt == '0) begin
                            state <= DONE;
                            ready <= 1'b0;
                        end else if ((change_amt % COIN_LO_RS) != '0) begin
                            err <= 1'b1;
                        end else begin
                            // Coin choice is registered here so the request
                            // is visible from the accepting edge onward.
                            state      <= REQ;
                            ready      <= 1'b0;
                            coin10_req <= pick_hi(change_amt, no_hi);
                            coin5_req  <= !pick_hi(change_amt, no_hi);
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (hopper_ack) begin
                        remain_amt <= remain_amt - coin_val;
                        coin10_req <= 1'b0;
                        coin5_req  <= 1'b0;
                        state      <= GAP;
                    end else if (tmr_expired) begin
                        fault      <= 1'b1;
                        coin10_req <= 1'b0;
                        coin5_req  <= 1'b0;
                        ready      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                GAP: begin
                    // Requests stay low for this cycle so the hopper always
                    // sees a fresh rising request for the next coin.
                    if (remain_amt == '0) begin
                        state <= DONE;
                    end else begin
                        state      <= REQ;
                        coin10_req <= pick_hi(remain_amt, no_hi);
                        coin5_req  <= !pick_hi(remain_amt, no_hi);
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    localparam int K_NONE  = 0;
    localparam int K_C10   = 1;
    localparam int K_C5    = 2;
    localparam int K_DONE  = 3;
    localparam int K_ERR   = 4;
    localparam int K_FAULT = 5;

    typedef struct {
        int kind;
        int rem;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       change_valid = 1'b0;
    logic [4:0] change_amt = '0;
    logic       hopper_ack = 1'b0;
`ifdef CHANGE_FALLBACK_EN
    logic       empty10 = 1'b0;
`endif
    logic       ready, coin10_req, coin5_req, done, err, fault;
    logic [4:0] remain_amt;

    ev_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  ack_delay = 0;
    bit  ack_en = 1'b1;
    int  req_cnt = 0;
    int  acc_cyc = 0;
    int  done_cyc = 0;
    int  cur_len = 0;
    int  last_len = 0;
    bit  p10 = 1'b0;
    bit  p5 = 1'b0;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .ready        (ready),
        .hopper_ack   (hopper_ack),
`ifdef CHANGE_FALLBACK_EN
        .empty10      (empty10),
`endif
        .coin10_req   (coin10_req),
        .coin5_req    (coin5_req),
        .done         (done),
        .err          (err),
        .fault        (fault),
        .remain_amt   (remain_amt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic see(input int kind, input int rem);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", kind, K_NONE);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_remain", rem, e.rem);
        end
    endtask

    // Monitor plus hopper model, both on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (coin10_req && !p10) see(K_C10, int'(remain_amt));
            if (coin5_req && !p5)   see(K_C5, int'(remain_amt));
            if (done) begin
                done_cyc = cyc;
                see(K_DONE, int'(remain_amt));
            end
            if (err)   see(K_ERR, int'(remain_amt));
            if (fault) see(K_FAULT, int'(remain_amt));
            chk("one_hot_req", int'(coin10_req && coin5_req), 0);
        end
        if (coin10_req || coin5_req) cur_len++;
        else if (cur_len != 0) begin
            last_len = cur_len;
            cur_len  = 0;
        end
        p10 = coin10_req;
        p5  = coin5_req;
        if (coin10_req || coin5_req) begin
            req_cnt++;
            hopper_ack = ack_en && (req_cnt > ack_delay);
        end else begin
            req_cnt    = 0;
            hopper_ack = 1'b0;
        end
    end

    // Reference model: expected event sequence for one amount.
    task automatic push_model(input int amt, input bit acks, input bit e10);
        int rem = amt;
        if (amt % 5 != 0) begin
            sb.push_back('{K_ERR, amt});
            return;
        end
        if (amt == 0) begin
            sb.push_back('{K_DONE, 0});
            return;
        end
        if (!acks) begin
            sb.push_back('{(amt >= 10 && !e10) ? K_C10 : K_C5, amt});
            sb.push_back('{K_FAULT, amt});
            return;
        end
        while (rem > 0) begin
            if (rem >= 10 && !e10) begin
                sb.push_back('{K_C10, rem});
                rem -= 10;
            end else begin
                sb.push_back('{K_C5, rem});
                rem -= 5;
            end
        end
        sb.push_back('{K_DONE, 0});
    endtask

    task automatic send(input int amt);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", int'(ready), 1);
        change_valid = 1'b1;
        change_amt   = 5'(amt);
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        change_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_left", sb.size(), 0);
        chk("ready_idle", int'(ready), 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(ready), 1);
        chk({tag, "_c10"}, int'(coin10_req), 0);
        chk({tag, "_c5"}, int'(coin5_req), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_remain"}, int'(remain_amt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // Rs15, ack two cycles after each request.
        ack_delay = 2;
        push_model(15, 1'b1, 1'b0);
        send(15);
        drain(100);

        // Rs15 with immediate acks: done visible after edge E+5.
        ack_delay = 0;
        push_model(15, 1'b1, 1'b0);
        send(15);
        drain(100);
        chk("lat_rs15", done_cyc - acc_cyc, 5);

        // Rs0: straight to done.
        push_model(0, 1'b1, 1'b0);
        send(0);
        drain(20);
        chk("lat_rs0", done_cyc - acc_cyc, 1);

        // Rs7 rejected, ready stays high, then Rs10 normally.
        push_model(7, 1'b1, 1'b0);
        send(7);
        chk("ready_after_bad", int'(ready), 1);
        drain(20);
        ack_delay = 1;
        push_model(10, 1'b1, 1'b0);
        send(10);
        drain(100);

        // Rs20, hopper never acks: 16-cycle request then fault.
        ack_en = 1'b0;
        push_model(20, 1'b0, 1'b0);
        send(20);
        drain(100);
        chk("timeout_hold", last_len, 16);
        chk("fault_remain_held", int'(remain_amt), 20);
        ack_en = 1'b1;

        // Rs30, reset during the second coin request.
        ack_delay = 2;
        sb.push_back('{K_C10, 30});
        sb.push_back('{K_C10, 20});
        send(30);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("second_coin_seen", sb.size(), 0);
        chk("second_coin_high", int'(coin10_req), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b1;
        push_model(5, 1'b1, 1'b0);
        send(5);
        drain(100);

`ifdef CHANGE_FALLBACK_EN
        // Rs10 tube empty: Rs10 paid as two Rs5 coins.
        empty10 = 1'b1;
        push_model(10, 1'b1, 1'b1);
        send(10);
        drain(100);
        empty10 = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
